// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the byte-serial RAM arbiter: bus types, access-size
// codes and the size-to-last-byte decode.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_W = 32;

  typedef logic [MEM_ADDR_W-1:0] MemAddrBus;
  typedef logic [31:0]           InstBus;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic {OWN_IF = 1'b0, OWN_MEM = 1'b1} owner_e;

  // Index of the final byte of an access; code 3 behaves like a word.
  function automatic logic [1:0] last_byte_idx(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 2'd0;
      LEN_HALF: return 2'd1;
      LEN_WORD: return 2'd3;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one byte-wide RAM port,
// splitting each access into LSB-first byte transfers with registered RAM pins.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output InstBus            if_data,
  input  logic              mem_req,
  input  logic              mem_write,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0]        cap_lane_q, cap_lane_d;
  logic              issued_q, issued_d;
  logic              cap_vld_q, cap_vld_d;
  logic              ram_wr_q, ram_wr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       data_q, data_d;

  logic [1:0]        cnt_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              grant_mem, grant_if, flush_own;

  assign cnt_nx    = cnt_q + 2'd1;
  assign addr_nx   = base_q + ADDR_W'(cnt_nx);
  assign grant_mem = mem_req;
  assign grant_if  = !mem_req && if_req && !if_flush;
  assign flush_own = if_flush && (owner_q == OWN_IF);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    base_d     = base_q;
    ram_addr_d = ram_addr_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    cap_lane_d = cap_lane_q;
    issued_d   = issued_q;
    cap_vld_d  = cap_vld_q;
    ram_wr_d   = ram_wr_q;
    ram_dout_d = ram_dout_q;
    wdata_d    = wdata_q;
    data_d     = data_q;

    case (state_q)
      S_IDLE: begin
        if (grant_mem || grant_if) begin
          owner_d    = grant_mem ? OWN_MEM : OWN_IF;
          base_d     = grant_mem ? mem_addr : if_addr;
          ram_addr_d = grant_mem ? mem_addr : if_addr;
          last_d     = grant_mem ? last_byte_idx(mem_len) : 2'd3;
          wdata_d    = grant_mem ? mem_wdata : 32'd0;
          cnt_d      = 2'd0;
          issued_d   = 1'b0;
          cap_vld_d  = 1'b0;
          data_d     = 32'd0;
          if (grant_mem && mem_write) begin
            state_d    = S_WRITE;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
          end else begin
            state_d = S_READ;
          end
        end
      end

      S_READ: begin
        // Each byte lands one cycle after its address, so capture lags issue.
        if (cap_vld_q) data_d[{cap_lane_q, 3'b000} +: 8] = ram_din;
        if (flush_own) begin
          state_d    = S_IDLE;
          ram_addr_d = '0;
          cap_vld_d  = 1'b0;
          issued_d   = 1'b0;
          cnt_d      = 2'd0;
          data_d     = 32'd0;
        end else if (!issued_q) begin
          cap_vld_d  = 1'b1;
          cap_lane_d = cnt_q;
          if (cnt_q == last_q) begin
            issued_d   = 1'b1;
            ram_addr_d = '0;
          end else begin
            cnt_d      = cnt_nx;
            ram_addr_d = addr_nx;
          end
        end else begin
          cap_vld_d = 1'b0;
          state_d   = S_DONE;
        end
      end

      S_WRITE: begin
        if (cnt_q == last_q) begin
          state_d    = S_DONE;
          ram_wr_d   = 1'b0;
          ram_addr_d = '0;
          ram_dout_d = 8'd0;
          cnt_d      = 2'd0;
        end else begin
          cnt_d      = cnt_nx;
          ram_addr_d = addr_nx;
          ram_dout_d = wdata_q[{cnt_nx, 3'b000} +: 8];
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = 2'd0;
        issued_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_IF;
      base_q     <= '0;
      ram_addr_q <= '0;
      last_q     <= 2'd0;
      cnt_q      <= 2'd0;
      cap_lane_q <= 2'd0;
      issued_q   <= 1'b0;
      cap_vld_q  <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_dout_q <= 8'd0;
      wdata_q    <= 32'd0;
      data_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      base_q     <= base_d;
      ram_addr_q <= ram_addr_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      cap_lane_q <= cap_lane_d;
      issued_q   <= issued_d;
      cap_vld_q  <= cap_vld_d;
      ram_wr_q   <= ram_wr_d;
      ram_dout_q <= ram_dout_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
    end
  end

  // A flush arriving in the IF done cycle still cancels that done.
  assign if_done   = (state_q == S_DONE) && (owner_q == OWN_IF) && !if_flush;
  assign mem_done  = (state_q == S_DONE) && (owner_q == OWN_MEM);
  assign if_data   = data_q;
  assign mem_rdata = data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a table of single accesses against a small
// RAM model, plus hand-written trace, contention, flush, wrap and reset cases.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_data;
  logic        mem_req, mem_write, mem_done;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [31:0] ram_addr;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  logic [7:0]  ram [0:4095] = '{default: 8'h00};
  int          wr_count = 0;
  logic        tb_we = 1'b0;
  logic [11:0] tb_wa = '0;
  logic [7:0]  tb_wd = '0;

  int n_tests = 0;
  int n_fail  = 0;

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_write(mem_write), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // 4 KiB RAM image aliased over the whole address space; read data one cycle late.
  always @(posedge clk) begin
    ram_din <= ram[ram_addr[11:0]];
    if (ram_wr === 1'b1) begin
      ram[ram_addr[11:0]] <= ram_dout;
      wr_count <= wr_count + 1;
    end else if (tb_we) begin
      ram[tb_wa] <= tb_wd;
    end
  end

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t vecs[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    step();
    tb_we = 1'b0;
  endtask

  task automatic wait_done(input bit is_if, input int max, output int lat);
    lat = 0;
    for (int c = 1; c <= max; c++) begin
      step();
      if ((is_if ? if_done : mem_done) === 1'b1) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic do_req(input vec_t v, output int lat, output logic [31:0] data,
                        output logic other);
    if (v.is_if) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_req = 1'b1; mem_write = v.wr; mem_len = v.len;
      mem_addr = v.addr; mem_wdata = v.wdata;
    end
    wait_done(v.is_if, 20, lat);
    data  = v.is_if ? if_data : mem_rdata;
    other = v.is_if ? mem_done : if_done;
    if_req = 1'b0; mem_req = 1'b0; mem_write = 1'b0;
    step();
  endtask

  logic [31:0] wrap_exp [4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

  initial begin
    int          lat;
    int          w0;
    logic [31:0] got;
    logic        other;

    reset = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_write = 1'b0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
    step();
    step();
    chk("reset_outputs", {ram_addr, ram_wr, ram_dout, if_done, mem_done, if_data, mem_rdata}, '0);

    poke(12'h100, 8'h13);
    poke(12'h200, 8'hF0);
    poke(12'h210, 8'h11); poke(12'h211, 8'h22); poke(12'h212, 8'h33); poke(12'h213, 8'h44);
    poke(12'h230, 8'h5A); poke(12'h231, 8'hA5); poke(12'h232, 8'hC3); poke(12'h233, 8'h3C);
    poke(12'h400, 8'h78); poke(12'h401, 8'h56); poke(12'h402, 8'h34); poke(12'h403, 8'h12);
    poke(12'hFFE, 8'hAA); poke(12'hFFF, 8'hBB); poke(12'h000, 8'hCC); poke(12'h001, 8'hDD);
    reset = 1'b1;
    step();

    // is_if, wr, len, addr, wdata, exp_data, exp_lat, exp_wr
    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h100, 32'h0,         32'h0000_0013, 6, 0};
    vecs[1]  = '{1'b0, 1'b0, 2'd0, 32'h200, 32'h0,         32'h0000_00F0, 3, 0};
    vecs[2]  = '{1'b0, 1'b0, 2'd1, 32'h210, 32'h0,         32'h0000_2211, 4, 0};
    vecs[3]  = '{1'b0, 1'b0, 2'd2, 32'h210, 32'h0,         32'h4433_2211, 6, 0};
    vecs[4]  = '{1'b0, 1'b0, 2'd3, 32'h230, 32'h0,         32'h3CC3_A55A, 6, 0};
    vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'h300, 32'hAABB_CCDD, 32'h0,         3, 2};
    vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h310, 32'h1234_5678, 32'h0,         5, 4};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 32'h320, 32'h0000_009E, 32'h0,         2, 1};
    vecs[8]  = '{1'b0, 1'b0, 2'd2, 32'h310, 32'h0,         32'h1234_5678, 6, 0};
    vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h301, 32'h0,         32'h0000_00CC, 3, 0};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h210, 32'h0,         32'h4433_2211, 6, 0};
    vecs[11] = '{1'b0, 1'b0, 2'd1, 32'h302, 32'h0,         32'h0000_0000, 4, 0};

    for (int i = 0; i < 12; i++) begin
      w0 = wr_count;
      do_req(vecs[i], lat, got, other);
      chk($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      if (!vecs[i].wr) chk($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      chk($sformatf("vec%0d_other_done", i), other, 1'b0);
      chk($sformatf("vec%0d_ram_writes", i), wr_count - w0, vecs[i].exp_wr);
    end
    chk("store_half_b0", ram[12'h300], 8'hDD);
    chk("store_half_b1", ram[12'h301], 8'hCC);
    chk("store_word_b3", ram[12'h313], 8'h12);
    chk("store_byte", ram[12'h320], 8'h9E);

    // IF word fetch address trace
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("fetch_addr_k%0d", k), {ram_addr, ram_wr}, {32'h100 + 32'(k), 1'b0});
    end
    step();
    chk("fetch_tail_idle_pins", {ram_addr, if_done}, '0);
    step();
    chk("fetch_done_data", {if_done, if_data}, {1'b1, 32'h0000_0013});
    if_req = 1'b0;
    step();
    chk("fetch_done_one_cycle", if_done, 1'b0);

    // Half store pin trace
    mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd1; mem_addr = 32'h340; mem_wdata = 32'hAABB_CCDD;
    w0 = wr_count;
    step();
    chk("hstore_t1", {ram_wr, ram_addr, ram_dout, mem_done}, {1'b1, 32'h340, 8'hDD, 1'b0});
    step();
    chk("hstore_t2", {ram_wr, ram_addr, ram_dout, mem_done}, {1'b1, 32'h341, 8'hCC, 1'b0});
    step();
    chk("hstore_t3", {ram_wr, ram_addr, ram_dout, mem_done}, {1'b0, 32'h0, 8'h00, 1'b1});
    mem_req = 1'b0; mem_write = 1'b0;
    step();
    chk("hstore_writes", wr_count - w0, 2);

    // Contention: MEM byte load wins, IF fetch follows
    mem_req = 1'b1; mem_len = 2'd0; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h100;
    step();
    chk("cont_mem_first", ram_addr, 32'h200);
    step();
    step();
    chk("cont_mem_done", {mem_done, mem_rdata, if_done}, {1'b1, 32'h0000_00F0, 1'b0});
    mem_req = 1'b0;
    step();
    chk("cont_if_sample_cycle", ram_addr, 32'h0);
    step();
    chk("cont_if_first_addr", ram_addr, 32'h100);
    wait_done(1'b1, 12, lat);
    chk("cont_if_latency", lat, 5);
    chk("cont_if_data", if_data, 32'h0000_0013);
    if_req = 1'b0;
    step();

    // Flush during READ, then a fresh fetch
    if_req = 1'b1; if_addr = 32'h210;
    step(); step(); step();
    if_flush = 1'b1;
    step();
    chk("flush_read_idle", {ram_addr, if_done, if_data}, '0);
    if_flush = 1'b0; if_addr = 32'h400;
    step();
    chk("flush_refetch_addr", ram_addr, 32'h400);
    wait_done(1'b1, 12, lat);
    chk("flush_refetch_latency", lat, 5);
    chk("flush_refetch_data", if_data, 32'h1234_5678);
    if_req = 1'b0;
    step();

    // Flush in the IF done cycle suppresses if_done
    if_req = 1'b1; if_addr = 32'h100;
    for (int k = 0; k < 6; k++) step();
    if_flush = 1'b1;
    #1;
    chk("flush_done_suppressed", if_done, 1'b0);
    if_req = 1'b0;
    step();
    if_flush = 1'b0;

    // Flush in IDLE blocks an IF grant for that cycle
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b1;
    step();
    chk("flush_idle_no_grant", ram_addr, 32'h0);
    if_flush = 1'b0;
    step();
    chk("flush_idle_next_grant", ram_addr, 32'h100);
    wait_done(1'b1, 12, lat);
    chk("flush_idle_latency", lat, 5);
    if_req = 1'b0;
    step();

    // MEM transfers ignore flush
    if_flush = 1'b1;
    mem_req = 1'b1; mem_write = 1'b0; mem_len = 2'd0; mem_addr = 32'h200;
    wait_done(1'b0, 10, lat);
    chk("mem_flush_immune", {lat, mem_rdata}, {32'd3, 32'h0000_00F0});
    mem_req = 1'b0; if_flush = 1'b0;
    step();

    // Address wrap past the top
    if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("wrap_addr_k%0d", k), ram_addr, wrap_exp[k]);
    end
    wait_done(1'b1, 6, lat);
    chk("wrap_latency", lat, 2);
    chk("wrap_data", if_data, 32'hDDCC_BBAA);
    if_req = 1'b0;
    step();

    // Reset in the middle of a word store
    mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = 32'hCAFE_BABE;
    step(); step(); step();
    chk("rst_pre_byte2", {ram_wr, ram_addr, ram_dout}, {1'b1, 32'h502, 8'hFE});
    reset = 1'b0;
    step();
    chk("rst_outputs", {ram_addr, ram_wr, ram_dout, if_done, mem_done, if_data, mem_rdata}, '0);
    mem_req = 1'b0; mem_write = 1'b0;
    reset = 1'b1;
    step(); step(); step();
    chk("rst_no_resume", {ram[12'h502], ram[12'h503], ram_wr}, {8'hFE, 8'h00, 1'b0});
    mem_req = 1'b1; mem_write = 1'b1; mem_len = 2'd2; mem_addr = 32'h500; mem_wdata = 32'h1122_3344;
    step();
    chk("rst_restart_byte0", {ram_wr, ram_addr, ram_dout}, {1'b1, 32'h500, 8'h44});
    wait_done(1'b0, 8, lat);
    chk("rst_restart_latency", lat, 4);
    mem_req = 1'b0; mem_write = 1'b0;
    step();
    chk("rst_restart_b3", ram[12'h503], 8'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
